aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES key expansion (FIPS-197 §5.2) for 128/192/256-bit keys. It produces one 32-bit schedule word per clock and presents the complete round-key array `k_sch[0:Nr]` to the pipelined cipher and inverse-cipher stages, which sit directly downstream. `key_ready` tells those stages when the schedule is complete and stable, so they can start accepting blocks.

## Interface
- `Nk`, 4: key length in 32-bit words (4, 6 or 8 only).
- `Nr`, `Nk+6`: number of rounds; the block produces `Nr+1` round keys.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `key_load`  in  1  single-cycle start strobe; samples `key`.
- `key`  in  `32*Nk`  cipher key; `key[32*Nk-1 -: 32]` is w[0] (FIPS byte order).
- `k_sch`  out  `128 x [0:Nr]`  round keys; `k_sch[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}`, with w[4r] in bits 127:96.
- `busy`  out  1  expansion in progress.
- `key_ready`  out  1  all `k_sch` entries are valid and stable.

## Operation
- Internal storage: word array w[0 : 4(Nr+1)-1], a word index `i`, a running Rcon byte and a position counter `i mod Nk`.
- State machine:
  - IDLE → EXPAND on `key_load`.
  - EXPAND → DONE after the last word is written.
  - DONE → EXPAND on `key_load`.
  - `key_load` in any state, including EXPAND, restarts from the newly sampled key.
- On load: w[0..Nk-1] ← `key`, i ← Nk, Rcon ← 0x01, `key_ready` ← 0, `busy` ← 1.
- Each EXPAND cycle writes w[i] = w[i-Nk] ^ temp, where temp is:
  - SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0} when i mod Nk == 0; Rcon then advances by xtime (0x80 → 0x1b).
  - SubWord(w[i-1]) when Nk == 8 and i mod Nk == 4.
  - w[i-1] otherwise.
- Only one SubWord (4 S-boxes) is instantiated. The i mod Nk tracker is a counter, not a divider.
- The last word is i = 4(Nr+1)-1. On that write: `busy` ← 0, `key_ready` ← 1, state ← DONE.
- `k_sch` is wired directly from w. Entries are meaningful only while `key_ready` = 1. During EXPAND, partial and old words are visible and must not be used.
- The schedule holds indefinitely in DONE.
- Downstream stages must not issue blocks while `key_ready` = 0. This block does not stall or track blocks already in flight.

## Timing
- Reset values: `busy` = 0, `key_ready` = 0, every w word = 0, so `k_sch` is all zero. State = IDLE, Rcon = 0x01.
- Edge 0 samples `key_load` = 1. Edges 1..L write w[Nk..4Nr+3], where L = 4(Nr+1)-Nk.
  - L = 40 for Nk=4, 46 for Nk=6, 52 for Nk=8.
- `busy` is high from after edge 0 through edge L-1. `key_ready` goes high after edge L, together with `busy` falling.
- `key_load` on the same edge as the final write: the load wins, `key_ready` stays 0 and a fresh L-cycle expansion starts.
- `key_load` held high for several cycles: the block restarts every cycle and `key_ready` rises L edges after the last high sample.
- Reset asserted mid-expansion: all outputs take their reset values immediately (asynchronous). After release the block waits in IDLE for the next `key_load`.
- `key` is sampled only at the load edge. Later changes to `key` have no effect.

## Test plan
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c:
  - `key_ready` rises exactly 40 edges after load.
  - `k_sch[1]` = a0fafe1788542cb123a339392a6c7605.
  - `k_sch[10]` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - ready after 46 edges.
  - w[51] = 01002202, i.e. `k_sch[12][31:0]`.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - ready after 52 edges.
  - w[59] = 706c631e, i.e. `k_sch[14][31:0]`.
- Nk=4, reload with key 000102…0f at edge 20 of an expansion:
  - `key_ready` stays 0 until 40 edges after the second load.
  - `k_sch[10]` = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset pulse at edge 15 of an expansion:
  - `busy` and `key_ready` are 0 and `k_sch` is all zero while `rst_n` is low.
  - A following load produces the correct schedule.
- Chained with the inverse cipher, key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a loaded once `key_ready` = 1 → pt 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule (128/192/256-bit keys): one 32-bit word per clock,
// with the whole round-key array exposed to the downstream cipher stages.
module aes_key_expand #(
    parameter int Nk = 4,
    localparam int Nr = Nk + 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [32*Nk-1:0] key,
    output logic [127:0]     k_sch [0:Nr],
    output logic             busy,
    output logic             key_ready
);
    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [2:0]    pos_q, pos_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          w_we;
    logic [31:0]   w_q [0:NW-1];
    logic [31:0]   prev_w, old_w, sub_in, sub_out, temp, new_w;

    // Entry 0 sits in the top byte of the table, so the index is 255-x = ~x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    always_comb begin
        prev_w  = w_q[i_q - IW'(1)];
        old_w   = w_q[i_q - IW'(Nk)];
        sub_in  = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
        end
        if (pos_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (Nk == 8 && pos_q == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = prev_w;
        end
        new_w = old_w ^ temp;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        w_we    = 1'b0;
        if (key_load) begin
            state_d = EXPAND;
            i_d     = IW'(Nk);
            pos_d   = '0;
            rcon_d  = 8'h01;
            busy_d  = 1'b1;
            ready_d = 1'b0;
        end else if (state_q == EXPAND) begin
            w_we  = 1'b1;
            i_d   = i_q + IW'(1);
            pos_d = (pos_q == 3'(Nk - 1)) ? '0 : pos_q + 3'd1;
            if (pos_q == 3'd0) begin
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            if (i_q == IW'(NW - 1)) begin
                state_d = DONE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            pos_q   <= '0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < NW; j++) begin
                w_q[j] <= '0;
            end
        end else if (key_load) begin
            for (int unsigned j = 0; j < Nk; j++) begin
                w_q[j] <= key[32*(Nk-1-j) +: 32];
            end
        end else if (w_we) begin
            w_q[i_q] <= new_w;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r <= Nr; r++) begin
            k_sch[r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
        end
    end

    assign busy      = busy_q;
    assign key_ready = ready_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: one instance per key length, checked against a
// FIPS-197 style reference expansion built from a computed (GF inverse) S-box.
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         kl4, kl6, kl8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [127:0] ks4 [0:10];
    logic [127:0] ks6 [0:12];
    logic [127:0] ks8 [0:14];
    logic         busy4, busy6, busy8, rdy4, rdy6, rdy8;

    int errors = 0;
    int checks = 0;

    logic [7:0]  sb_m  [0:255];
    logic [7:0]  isb_m [0:255];
    logic [31:0] exp_w [0:59];

    always #5 clk = ~clk;

    aes_key_expand #(.Nk(4)) dut4 (.clk(clk), .rst_n(rst_n), .key_load(kl4), .key(key4),
                                   .k_sch(ks4), .busy(busy4), .key_ready(rdy4));
    aes_key_expand #(.Nk(6)) dut6 (.clk(clk), .rst_n(rst_n), .key_load(kl6), .key(key6),
                                   .k_sch(ks6), .busy(busy6), .key_ready(rdy6));
    aes_key_expand #(.Nk(8)) dut8 (.clk(clk), .rst_n(rst_n), .key_load(kl8), .key(key8),
                                   .k_sch(ks8), .busy(busy8), .key_ready(rdy8));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb_m[x]  = s;
            isb_m[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subword_m(input logic [31:0] w);
        return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) exp_w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t  = subword_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword_m(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [127:0] v;
        v = ct ^ ks4[10];
        for (int r = 9; r >= 0; r--) begin
            for (int b = 0; b < 16; b++) s[b] = v[127-8*b -: 8];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*((c + row) % 4)] = isb_m[s[row + 4*c]];
            for (int b = 0; b < 16; b++) v[127-8*b -: 8] = t[b];
            v = v ^ ks4[r];
            if (r > 0) begin
                for (int b = 0; b < 16; b++) s[b] = v[127-8*b -: 8];
                for (int c = 0; c < 4; c++) begin
                    t[4*c]   = gmul(s[4*c],8'd14) ^ gmul(s[4*c+1],8'd11) ^ gmul(s[4*c+2],8'd13) ^ gmul(s[4*c+3],8'd9);
                    t[4*c+1] = gmul(s[4*c],8'd9)  ^ gmul(s[4*c+1],8'd14) ^ gmul(s[4*c+2],8'd11) ^ gmul(s[4*c+3],8'd13);
                    t[4*c+2] = gmul(s[4*c],8'd13) ^ gmul(s[4*c+1],8'd9)  ^ gmul(s[4*c+2],8'd14) ^ gmul(s[4*c+3],8'd11);
                    t[4*c+3] = gmul(s[4*c],8'd11) ^ gmul(s[4*c+1],8'd13) ^ gmul(s[4*c+2],8'd9)  ^ gmul(s[4*c+3],8'd14);
                end
                for (int b = 0; b < 16; b++) v[127-8*b -: 8] = t[b];
            end
        end
        return v;
    endfunction

    // ---------------- DUT access ----------------
    function automatic logic [127:0] dut_rk(input int nk, input int r);
        case (nk)
            4:       return ks4[r];
            6:       return ks6[r];
            default: return ks8[r];
        endcase
    endfunction

    function automatic logic [31:0] dut_word(input int nk, input int idx);
        logic [127:0] rk;
        rk = dut_rk(nk, idx / 4);
        return rk[127-32*(idx%4) -: 32];
    endfunction

    function automatic logic dut_ready(input int nk);
        return (nk == 4) ? rdy4 : (nk == 6) ? rdy6 : rdy8;
    endfunction

    function automatic logic dut_busy(input int nk);
        return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
        return k;
    endfunction

    task automatic do_load(input int nk, input logic [255:0] k);
        @(negedge clk);
        case (nk)
            4:       begin kl4 = 1'b1; key4 = k[255:128]; end
            6:       begin kl6 = 1'b1; key6 = k[255:64];  end
            default: begin kl8 = 1'b1; key8 = k;          end
        endcase
        @(posedge clk);
        #1;
        kl4 = 1'b0; kl6 = 1'b0; kl8 = 1'b0;
        key4 = {$urandom, $urandom, $urandom, $urandom};
        key6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Counts edges after the load edge until key_ready; flags any pre-ready cycle without busy.
    task automatic wait_ready(input int nk, output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        while (!dut_ready(nk) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!dut_ready(nk) && !dut_busy(nk)) busy_bad++;
        end
    endtask

    task automatic check_sched(input int nk, input string tag);
        logic [127:0] e;
        logic [127:0] g;
        for (int r = 0; r <= nk + 6; r++) begin
            e = {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
            g = dut_rk(nk, r);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s nk=%0d rk[%0d]: got %h expected %h", tag, nk, r, g, e);
            end
        end
    endtask

    task automatic check_ready_cycle(input int nk, input string tag, input int exp_n);
        int n;
        int bb;
        wait_ready(nk, n, bb);
        checks++;
        if (n !== exp_n || bb !== 0 || dut_busy(nk) !== 1'b0) begin
            errors++;
            $display("FAIL %s nk=%0d latency: got %0d edges (busy gaps %0d, busy %b) expected %0d edges, busy 0",
                     tag, nk, n, bb, dut_busy(nk), exp_n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic bad;
        bad = 1'b0;
        for (int r = 0; r <= 10; r++) if (ks4[r] !== '0) bad = 1'b1;
        for (int r = 0; r <= 12; r++) if (ks6[r] !== '0) bad = 1'b1;
        for (int r = 0; r <= 14; r++) if (ks8[r] !== '0) bad = 1'b1;
        checks++;
        if (bad || {busy4, busy6, busy8, rdy4, rdy6, rdy8} !== 6'b0) begin
            errors++;
            $display("FAIL %s: got busy=%b%b%b ready=%b%b%b nonzero_ksch=%b expected all 0",
                     tag, busy4, busy6, busy8, rdy4, rdy6, rdy8, bad);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        kl4 = 1'b0; kl6 = 1'b0; kl8 = 1'b0;
        key4 = '0; key6 = '0; key8 = '0;
        #12;
        check_all_zero("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_fips_nk4();
        logic [255:0] k;
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        model_expand(4, k);
        do_load(4, k);
        checks++;
        if (busy4 !== 1'b1 || rdy4 !== 1'b0) begin
            errors++;
            $display("FAIL fips4_after_load: got busy=%b ready=%b expected busy=1 ready=0", busy4, rdy4);
        end
        check_ready_cycle(4, "fips4", 40);
        checks++;
        if (ks4[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips4_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", ks4[1]);
        end
        checks++;
        if (ks4[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips4_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", ks4[10]);
        end
        check_sched(4, "fips4_model");
    endtask

    task automatic test_fips_wide(input int nk, input logic [255:0] k, input int lat,
                                  input int widx, input logic [31:0] wexp);
        model_expand(nk, k);
        do_load(nk, k);
        check_ready_cycle(nk, "fips_wide", lat);
        checks++;
        if (dut_word(nk, widx) !== wexp) begin
            errors++;
            $display("FAIL fips%0d_w%0d: got %h expected %h", nk, widx, dut_word(nk, widx), wexp);
        end
        check_sched(nk, "fips_wide_model");
    endtask

    task automatic test_random();
        int nk;
        logic [255:0] k;
        for (int it = 0; it < 6; it++) begin
            nk = 4 + 2 * $urandom_range(0, 2);
            k = rand_key();
            model_expand(nk, k);
            do_load(nk, k);
            check_ready_cycle(nk, "random", 4 * (nk + 7) - nk);
            check_sched(nk, "random_model");
            repeat ($urandom_range(3, 20)) @(posedge clk);
            #1;
            checks++;
            if (dut_ready(nk) !== 1'b1 || dut_word(nk, 4*(nk+7)-1) !== exp_w[4*(nk+7)-1]) begin
                errors++;
                $display("FAIL random_hold nk=%0d: got ready=%b last=%h expected ready=1 last=%h",
                         nk, dut_ready(nk), dut_word(nk, 4*(nk+7)-1), exp_w[4*(nk+7)-1]);
            end
        end
    endtask

    task automatic test_reload_mid();
        logic [255:0] k2;
        k2 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        do_load(4, rand_key());
        repeat (19) @(posedge clk);
        #1;
        do_load(4, k2);
        checks++;
        if (rdy4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL reload_mid_state: got busy=%b ready=%b expected busy=1 ready=0", busy4, rdy4);
        end
        check_ready_cycle(4, "reload_mid", 40);
        checks++;
        if (ks4[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            errors++;
            $display("FAIL reload_mid_rk10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", ks4[10]);
        end
        model_expand(4, k2);
        check_sched(4, "reload_mid_model");
    endtask

    task automatic test_load_on_final_edge();
        logic [255:0] k;
        k = rand_key();
        do_load(4, rand_key());
        repeat (39) @(posedge clk);
        #1;
        do_load(4, k);
        checks++;
        if (rdy4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL final_edge_load: got busy=%b ready=%b expected busy=1 ready=0", busy4, rdy4);
        end
        check_ready_cycle(4, "final_edge_load", 40);
        model_expand(4, k);
        check_sched(4, "final_edge_model");
    endtask

    task automatic test_held_load();
        logic [255:0] k;
        k = '0;
        @(negedge clk);
        kl4 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            k = rand_key();
            key4 = k[255:128];
            @(posedge clk);
            #1;
        end
        kl4 = 1'b0;
        key4 = {$urandom, $urandom, $urandom, $urandom};
        check_ready_cycle(4, "held_load", 40);
        model_expand(4, k);
        check_sched(4, "held_load_model");
    endtask

    task automatic test_async_reset();
        logic [255:0] k;
        do_load(4, rand_key());
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_now");
        @(posedge clk);
        #1;
        check_all_zero("async_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b0 || ks4[10] !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b ready=%b rk10=%h expected 0 0 0", busy4, rdy4, ks4[10]);
        end
        k = rand_key();
        model_expand(4, k);
        do_load(4, k);
        check_ready_cycle(4, "post_reset_load", 40);
        check_sched(4, "post_reset_model");
    endtask

    task automatic test_inv_cipher();
        logic [127:0] pt;
        do_load(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        check_ready_cycle(4, "inv_cipher_key", 40);
        pt = inv_cipher(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checks++;
        if (pt !== 128'h00112233445566778899aabbccddeeff) begin
            errors++;
            $display("FAIL inv_cipher_pt: got %h expected 00112233445566778899aabbccddeeff", pt);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_nk4();
        test_fips_wide(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 46, 51, 32'h01002202);
        test_fips_wide(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 52, 59, 32'h706c631e);
        test_random();
        test_reload_mid();
        test_load_on_final_edge();
        test_held_load();
        test_async_reset();
        test_inv_cipher();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
